// File: rtl/counter_pkg.sv
// ============================================================================
// Module   : counter_pkg
// Brief    : Shared direction constants and load clamp helper for the
//            up/down counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_prescaler.sv
// ============================================================================
// Module   : counter_prescaler
// Brief    : Counts enabled cycles and issues one step every PRESCALE of them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module counter_prescaler #(
  parameter int PRESCALE = 1,
  parameter int CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_passthru
      // A restart cycle never steps; the count path gives clear/load priority anyway.
      assign step = enable & ~restart;
    end else begin : g_count
      localparam logic [CW-1:0] c_LAST = CW'(PRESCALE - 1);
      logic [CW-1:0] r_count;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_count <= '0;
        end else if (restart) begin
          r_count <= '0;
        end else if (enable) begin
          r_count <= (r_count == c_LAST) ? '0 : r_count + CW'(1);
        end
      end

      assign step = enable & ~restart & (r_count == c_LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ============================================================================
// Module   : mod_updown_counter
// Brief    : WIDTH-bit modulo up/down counter with clear, clamped load,
//            enable prescaler, terminal count and wrap pulse.
//            Define MOD_UPDOWN_COUNTER_SATURATE_EN to saturate instead of wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_VALUE   = 2**WIDTH - 1,
  parameter int PRESCALE    = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] c_RESET = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_step;
  logic             w_restart;
  logic             w_up;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_roll;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;

  assign w_restart = clear | load;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .restart (w_restart),
    .step    (w_step)
  );

  assign w_up       = (up_down == DIR_UP);
  assign w_at_max   = (r_count == c_MAX);
  assign w_at_zero  = (r_count == '0);
  assign w_roll     = w_up ? w_at_max : w_at_zero;
  assign w_load_val = WIDTH'(clamp_to_max(32'(load_value), 32'(MAX_VALUE)));

  // Explicit wrap at the modulus so non-power-of-two MAX_VALUE never rolls naturally.
  assign w_next = w_up ? (w_at_max  ? '0    : r_count + WIDTH'(1))
                       : (w_at_zero ? c_MAX : r_count - WIDTH'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= c_RESET;
      r_wrap  <= 1'b0;
    end else if (clear) begin
      r_count <= c_RESET;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
      if (w_roll) begin
        r_wrap <= 1'b1;
      end else begin
        r_count <= w_next;
        r_wrap  <= 1'b0;
      end
`else
      r_count <= w_next;
      r_wrap  <= w_roll;
`endif
    end else begin
`ifndef MOD_UPDOWN_COUNTER_SATURATE_EN
      r_wrap <= 1'b0;
`endif
    end
  end

  assign count_out = r_count;
  assign wrap      = r_wrap;
  assign tc        = (w_at_max & (up_down == DIR_UP)) | (w_at_zero & (up_down == DIR_DOWN));

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ============================================================================
// Module   : tb_mod_updown_counter
// Brief    : Randomised and directed bench for two counter instances
//            (PRESCALE=1/RESET_VALUE=0 and PRESCALE=3/RESET_VALUE=2, MAX_VALUE=9).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod_updown_counter;

  localparam int MAXV = 9;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       up_down = 1'b1;
  logic [3:0] load_value = '0;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, wrap_a, wrap_b;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt [2];
  int m_pre [2];
  int m_wrap[2];

  always #5 clock = ~clock;

  mod_updown_counter #(.WIDTH(4), .MAX_VALUE(MAXV), .PRESCALE(1), .RESET_VALUE(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up_down(up_down), .count_out(cnt_a), .tc(tc_a), .wrap(wrap_a));

  mod_updown_counter #(.WIDTH(4), .MAX_VALUE(MAXV), .PRESCALE(3), .RESET_VALUE(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up_down(up_down), .count_out(cnt_b), .tc(tc_b), .wrap(wrap_b));

  function automatic int ps(int k);  return (k == 0) ? 1 : 3; endfunction
  function automatic int rv(int k);  return (k == 0) ? 0 : 2; endfunction
  function automatic logic [3:0] dut_cnt(int k); return (k == 0) ? cnt_a : cnt_b; endfunction
  function automatic logic dut_tc(int k);   return (k == 0) ? tc_a : tc_b; endfunction
  function automatic logic dut_wrap(int k); return (k == 0) ? wrap_a : wrap_b; endfunction
  function automatic logic exp_tc(int k);
    return ((m_cnt[k] == MAXV) && up_down) || ((m_cnt[k] == 0) && !up_down);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = rv(k); m_pre[k] = 0; m_wrap[k] = 0;
    end
  endtask

  // Reference: count modulo MAXV+1; every PRESCALE-th enabled cycle is a step.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit stp, blocked;
      stp = 0;
      if (!reset_n || clear) begin
        m_cnt[k] = rv(k); m_pre[k] = 0; m_wrap[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
        m_pre[k] = 0; m_wrap[k] = 0;
      end else begin
        if (enable) begin
          m_pre[k]++;
          if (m_pre[k] == ps(k)) begin m_pre[k] = 0; stp = 1; end
        end
        blocked = up_down ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0);
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
        if (stp) begin
          if (blocked) m_wrap[k] = 1;
          else begin m_cnt[k] = m_cnt[k] + (up_down ? 1 : -1); m_wrap[k] = 0; end
        end
`else
        if (stp) begin
          m_cnt[k]  = (m_cnt[k] + (up_down ? 1 : MAXV)) % (MAXV + 1);
          m_wrap[k] = blocked ? 1 : 0;
        end else m_wrap[k] = 0;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (dut_cnt(k) !== 4'(m_cnt[k])) begin n_fail++; $display("FAIL reset cnt[%0d] got %0d exp %0d", k, dut_cnt(k), m_cnt[k]); end
      n_tests++; if (dut_tc(k) !== exp_tc(k)) begin n_fail++; $display("FAIL reset tc[%0d] got %0b exp %0b", k, dut_tc(k), exp_tc(k)); end
      n_tests++; if (dut_wrap(k) !== m_wrap[k][0]) begin n_fail++; $display("FAIL reset wrap[%0d] got %0b exp %0b", k, dut_wrap(k), m_wrap[k][0]); end
    end
    n_tests++; if (cnt_b !== 4'd2) begin n_fail++; $display("FAIL reset_value cnt_b got %0d exp 2", cnt_b); end
    reset_n = 1'b1;
  endtask

  task automatic test_count_up();
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++; if (dut_cnt(k) !== 4'(m_cnt[k])) begin n_fail++; $display("FAIL up cnt[%0d] cyc %0d got %0d exp %0d", k, i, dut_cnt(k), m_cnt[k]); end
        n_tests++; if (dut_tc(k) !== exp_tc(k)) begin n_fail++; $display("FAIL up tc[%0d] cyc %0d got %0b exp %0b", k, i, dut_tc(k), exp_tc(k)); end
        n_tests++; if (dut_wrap(k) !== m_wrap[k][0]) begin n_fail++; $display("FAIL up wrap[%0d] cyc %0d got %0b exp %0b", k, i, dut_wrap(k), m_wrap[k][0]); end
      end
      if (i == 9) begin
        n_tests++; if (cnt_a !== 4'd9 || tc_a !== 1'b1) begin n_fail++; $display("FAIL up_top cnt_a/tc_a got %0d/%0b exp 9/1", cnt_a, tc_a); end
      end
`ifndef MOD_UPDOWN_COUNTER_SATURATE_EN
      if (i == 10) begin
        n_tests++; if (cnt_a !== 4'd0 || wrap_a !== 1'b1) begin n_fail++; $display("FAIL up_wrap cnt_a/wrap_a got %0d/%0b exp 0/1", cnt_a, wrap_a); end
      end
`endif
    end
  endtask

  task automatic test_count_down();
    clear = 1'b1; tick(); clear = 1'b0;
    up_down = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++; if (dut_cnt(k) !== 4'(m_cnt[k])) begin n_fail++; $display("FAIL down cnt[%0d] cyc %0d got %0d exp %0d", k, i, dut_cnt(k), m_cnt[k]); end
        n_tests++; if (dut_tc(k) !== exp_tc(k)) begin n_fail++; $display("FAIL down tc[%0d] cyc %0d got %0b exp %0b", k, i, dut_tc(k), exp_tc(k)); end
        n_tests++; if (dut_wrap(k) !== m_wrap[k][0]) begin n_fail++; $display("FAIL down wrap[%0d] cyc %0d got %0b exp %0b", k, i, dut_wrap(k), m_wrap[k][0]); end
      end
`ifndef MOD_UPDOWN_COUNTER_SATURATE_EN
      if (i == 1) begin
        n_tests++; if (cnt_a !== 4'd9 || wrap_a !== 1'b1) begin n_fail++; $display("FAIL down_wrap cnt_a/wrap_a got %0d/%0b exp 9/1", cnt_a, wrap_a); end
      end
`endif
    end
  endtask

  task automatic test_load_clear();
    enable = 1'b1; up_down = 1'b1;
    load = 1'b1; load_value = 4'hC; tick();
    n_tests++; if (cnt_a !== 4'd9 || cnt_b !== 4'd9) begin n_fail++; $display("FAIL load_clamp cnt_a/cnt_b got %0d/%0d exp 9/9", cnt_a, cnt_b); end
    clear = 1'b1; load_value = 4'h5; tick();
    n_tests++; if (cnt_a !== 4'd0 || cnt_b !== 4'd2) begin n_fail++; $display("FAIL clear_over_load cnt_a/cnt_b got %0d/%0d exp 0/2", cnt_a, cnt_b); end
    clear = 1'b0; tick();
    n_tests++; if (cnt_a !== 4'd5 || wrap_a !== 1'b0) begin n_fail++; $display("FAIL load5 cnt_a/wrap_a got %0d/%0b exp 5/0", cnt_a, wrap_a); end
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++; if (dut_cnt(k) !== 4'(m_cnt[k])) begin n_fail++; $display("FAIL load cnt[%0d] got %0d exp %0d", k, dut_cnt(k), m_cnt[k]); end
    end
  endtask

  task automatic test_prescale();
    bit pat[4] = '{1, 1, 0, 1};
    clear = 1'b1; tick(); clear = 1'b0;
    up_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enable = pat[i]; tick();
      n_tests++; if (cnt_b !== 4'(m_cnt[1])) begin n_fail++; $display("FAIL prescale cnt_b step %0d got %0d exp %0d", i, cnt_b, m_cnt[1]); end
    end
    n_tests++; if (cnt_b !== 4'd3) begin n_fail++; $display("FAIL prescale_step cnt_b got %0d exp 3", cnt_b); end
    enable = 1'b1; tick(); tick();
    load = 1'b1; load_value = 4'd5; tick(); load = 1'b0;
    tick(); tick();
    n_tests++; if (cnt_b !== 4'd5) begin n_fail++; $display("FAIL prescale_restart cnt_b got %0d exp 5", cnt_b); end
    tick();
    n_tests++; if (cnt_b !== 4'd6 || cnt_b !== 4'(m_cnt[1])) begin n_fail++; $display("FAIL prescale_after_load cnt_b got %0d exp 6", cnt_b); end
  endtask

  task automatic test_async_reset();
    up_down = 1'b1; enable = 1'b1;
    load = 1'b1; load_value = 4'd4; tick(); load = 1'b0;
    tick(); tick();
    n_tests++; if (cnt_a !== 4'd6) begin n_fail++; $display("FAIL areset_setup cnt_a got %0d exp 6", cnt_a); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++; if (cnt_a !== 4'd0 || cnt_b !== 4'd2) begin n_fail++; $display("FAIL areset_now cnt_a/cnt_b got %0d/%0d exp 0/2", cnt_a, cnt_b); end
    n_tests++; if (wrap_a !== 1'b0 || wrap_b !== 1'b0) begin n_fail++; $display("FAIL areset_wrap got %0b/%0b exp 0/0", wrap_a, wrap_b); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++; if (cnt_b !== 4'(m_cnt[1])) begin n_fail++; $display("FAIL areset_prescale cnt_b cyc %0d got %0d exp %0d", i, cnt_b, m_cnt[1]); end
    end
    n_tests++; if (cnt_b !== 4'd3) begin n_fail++; $display("FAIL areset_first_step cnt_b got %0d exp 3", cnt_b); end
  endtask

`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
  task automatic test_saturate();
    clear = 1'b1; tick(); clear = 1'b0;
    enable = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    n_tests++; if (cnt_a !== 4'd9 || wrap_a !== 1'b1) begin n_fail++; $display("FAIL sat_hold cnt_a/wrap_a got %0d/%0b exp 9/1", cnt_a, wrap_a); end
    up_down = 1'b0; tick();
    n_tests++; if (cnt_a !== 4'd8 || wrap_a !== 1'b0) begin n_fail++; $display("FAIL sat_release cnt_a/wrap_a got %0d/%0b exp 8/0", cnt_a, wrap_a); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear      = ($urandom_range(0, 19) == 0);
      load       = ($urandom_range(0, 14) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      up_down    = (i % 64 < 40) ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 7) == 0);
      load_value = 4'($urandom_range(0, 15));
      tick();
      for (int k = 0; k < 2; k++) begin
        n_tests++; if (dut_cnt(k) !== 4'(m_cnt[k])) begin n_fail++; $display("FAIL rand cnt[%0d] it %0d got %0d exp %0d", k, i, dut_cnt(k), m_cnt[k]); end
        n_tests++; if (dut_tc(k) !== exp_tc(k)) begin n_fail++; $display("FAIL rand tc[%0d] it %0d got %0b exp %0b", k, i, dut_tc(k), exp_tc(k)); end
        n_tests++; if (dut_wrap(k) !== m_wrap[k][0]) begin n_fail++; $display("FAIL rand wrap[%0d] it %0d got %0b exp %0b", k, i, dut_wrap(k), m_wrap[k][0]); end
      end
    end
    clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clear();
    test_prescale();
    test_async_reset();
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
